// File: rtl/output_port_allocator.sv
// Switch allocator for a 5-port wormhole router (N=4, E=3, W=2, S=1, L=0).
// Every output port does its own round-robin arbitration among packet heads.
// After a multi-flit head wins, the output stays locked to that input until
// the tail flit passes. A flit moves only when downstream credit is available.
// Grants are combinational, so a flit is forwarded in the cycle it is granted.
// Lock, owner, round-robin pointer and error flag are registered.
//
// Per-output lock FSM:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | no packet in flight; heads compete round-robin from ptr
//   ST_LOCKED | owner's packet in flight; only owner's body/tail served

module output_port_allocator #(
    parameter int NUM_PORTS = 5,
    parameter int RR_RESET  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req_valid_i,
    input  logic [NUM_PORTS-1:0]           req_head_i,
    input  logic [NUM_PORTS-1:0]           req_tail_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_dir_i,
    input  logic [NUM_PORTS-1:0]           credit_avail_i,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
    output logic [NUM_PORTS-1:0]           send_o,
    output logic [NUM_PORTS-1:0]           out_valid_o,
    output logic [NUM_PORTS-1:0]           locked_o,
    output logic                           err_o
);

    localparam int NP = NUM_PORTS;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_e;

    lock_e        r_lock      [NP];
    logic [2:0]   r_owner     [NP];
    logic [2:0]   r_ptr       [NP];
    logic         r_err;

    lock_e        w_lock_nxt  [NP];
    logic [2:0]   w_owner_nxt [NP];
    logic [2:0]   w_ptr_nxt   [NP];
    logic         w_err_nxt;

    logic [NP-1:0] w_legal;
    logic [NP-1:0] w_tgt      [NP];
    logic [NP-1:0] w_cand     [NP];
    logic [3:0]    w_pick     [NP];
    logic [NP-1:0] w_gsel     [NP];
    logic [NP-1:0] w_out_valid;
    logic [NP-1:0] w_send;
    logic [NP-1:0] w_locked;

    // Modulo-NP increment of an input index.
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        logic [2:0] res;
        if (idx == 3'(NP - 1)) begin
            res = 3'd0;
        end else begin
            res = idx + 3'd1;
        end
        return res;
    endfunction

    // First candidate at or after ptr, wrapping; result is {found, index}.
    function automatic logic [3:0] rr_pick(input logic [NP-1:0] cand,
                                           input logic [2:0]    ptr);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        idx = ptr;
        for (int k = 0; k < NP; k++) begin
            if (!res[3] && cand[idx]) begin
                res = {1'b1, idx};
            end
            idx = rr_next(idx);
        end
        return res;
    endfunction

    // Request legality, per-output target masks and round-robin winners among heads.
    always_comb begin
        w_legal = '0;
        for (int o = 0; o < NP; o++) begin
            w_tgt[o]  = '0;
            w_cand[o] = '0;
            w_pick[o] = '0;
        end
        for (int i = 0; i < NP; i++) begin
            // A U-turn (dir bit equal to the input's own index) is never legal.
            w_legal[i] = req_valid_i[i]
                       && $onehot(req_dir_i[i*NP +: NP])
                       && !req_dir_i[i*NP + i];
        end
        for (int o = 0; o < NP; o++) begin
            for (int i = 0; i < NP; i++) begin
                w_tgt[o][i] = w_legal[i] && req_dir_i[i*NP + o];
            end
            w_cand[o] = w_tgt[o] & req_head_i;
            w_pick[o] = rr_pick(w_cand[o], r_ptr[o]);
        end
    end

    // Per-output grant decision, next lock/owner/pointer state and error detection.
    always_comb begin
        w_out_valid = '0;
        w_err_nxt   = |(req_valid_i & ~w_legal);
        for (int o = 0; o < NP; o++) begin
            w_gsel[o]      = '0;
            w_lock_nxt[o]  = r_lock[o];
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
        end
        for (int o = 0; o < NP; o++) begin
            if (r_lock[o] == ST_IDLE) begin
                // Body or tail flits cannot start a packet.
                if (|(w_tgt[o] & ~req_head_i)) begin
                    w_err_nxt = 1'b1;
                end
                if (w_pick[o][3] && credit_avail_i[o]) begin
                    w_gsel[o]      = {{(NP-1){1'b0}}, 1'b1} << w_pick[o][2:0];
                    w_out_valid[o] = 1'b1;
                    w_ptr_nxt[o]   = rr_next(w_pick[o][2:0]);
                    if (!req_tail_i[w_pick[o][2:0]]) begin
                        w_lock_nxt[o]  = ST_LOCKED;
                        w_owner_nxt[o] = w_pick[o][2:0];
                    end
                end
            end else begin
                // Other inputs aimed here simply wait. An owner that stays silent stalls the packet.
                if (w_legal[r_owner[o]]) begin
                    if (w_tgt[o][r_owner[o]] && !req_head_i[r_owner[o]]) begin
                        if (credit_avail_i[o]) begin
                            w_gsel[o]      = {{(NP-1){1'b0}}, 1'b1} << r_owner[o];
                            w_out_valid[o] = 1'b1;
                            if (req_tail_i[r_owner[o]]) begin
                                w_lock_nxt[o] = ST_IDLE;
                            end
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
        end
        if (rst) begin
            w_out_valid = '0;
            for (int o = 0; o < NP; o++) begin
                w_gsel[o] = '0;
            end
        end
    end

    // Pack the crossbar selects, OR the grants per input into the dequeue strobe, and expose the lock bits.
    always_comb begin
        grant_o  = '0;
        w_send   = '0;
        w_locked = '0;
        for (int o = 0; o < NP; o++) begin
            grant_o[o*NP +: NP] = w_gsel[o];
            w_send              = w_send | w_gsel[o];
            w_locked[o]         = (r_lock[o] == ST_LOCKED);
        end
    end

    assign send_o      = w_send;
    assign out_valid_o = w_out_valid;
    assign locked_o    = w_locked;
    assign err_o       = r_err;

    // State register. A synchronous reset drops every lock at once; flushing flits is left to the buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NP; o++) begin
                r_lock[o]  <= ST_IDLE;
                r_owner[o] <= 3'd0;
                r_ptr[o]   <= 3'(RR_RESET);
            end
            r_err <= 1'b0;
        end else begin
            for (int o = 0; o < NP; o++) begin
                r_lock[o]  <= w_lock_nxt[o];
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
            r_err <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator. Every expected value is worked out by hand.
module tb_output_port_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_valid_i, req_head_i, req_tail_i, credit_avail_i;
    logic [24:0] req_dir_i;
    logic [24:0] grant_o;
    logic [4:0]  send_o, out_valid_o, locked_o;
    logic        err_o;

    int n_checks = 0;
    int n_errors = 0;

    output_port_allocator #(.NUM_PORTS(5), .RR_RESET(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_head_i     (req_head_i),
        .req_tail_i     (req_tail_i),
        .req_dir_i      (req_dir_i),
        .credit_avail_i (credit_avail_i),
        .grant_o        (grant_o),
        .send_o         (send_o),
        .out_valid_o    (out_valid_o),
        .locked_o       (locked_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] gv(input int o, input logic [4:0] sel);
        logic [24:0] v;
        v = '0;
        v[o*5 +: 5] = sel;
        return v;
    endfunction

    task automatic clr();
        req_valid_i = '0;
        req_head_i  = '0;
        req_tail_i  = '0;
        req_dir_i   = '0;
    endtask

    task automatic rq(input int i, input logic h, input logic t, input logic [4:0] d);
        req_valid_i[i]      = 1'b1;
        req_head_i[i]       = h;
        req_tail_i[i]       = t;
        req_dir_i[i*5 +: 5] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with random traffic
        rst = 1'b1;
        req_valid_i = 5'($urandom); req_head_i = 5'($urandom); req_tail_i = 5'($urandom);
        req_dir_i = 25'($urandom); credit_avail_i = 5'($urandom);
        tick();
        chk("rst1_grant", grant_o, '0);
        chk("rst1_send", {20'd0, send_o}, '0);
        chk("rst1_oval", {20'd0, out_valid_o}, '0);
        chk("rst1_locked", {20'd0, locked_o}, '0);
        req_valid_i = 5'($urandom); req_head_i = 5'($urandom); req_dir_i = 25'($urandom);
        #1;
        chk("rst2_grant", grant_o, '0);
        chk("rst2_send", {20'd0, send_o}, '0);
        tick();
        chk("rst2_locked", {20'd0, locked_o}, '0);
        chk("rst2_err", {24'd0, err_o}, '0);
        rst = 1'b0;
        clr();
        credit_avail_i = '0;
        tick();
        chk("post_rst_err", {24'd0, err_o}, '0);

        // L single-flit packet to E
        rq(0, 1, 1, 5'b01000); credit_avail_i = 5'b01000;
        #1;
        chk("l_e_grant", grant_o, gv(3, 5'b00001));
        chk("l_e_send", {20'd0, send_o}, 25'b00001);
        chk("l_e_oval", {20'd0, out_valid_o}, 25'b01000);
        tick();
        chk("l_e_locked", {20'd0, locked_o}, '0);
        chk("l_e_err", {24'd0, err_o}, '0);

        // W and S heads to N: S wins from ptr 0
        clr(); credit_avail_i = 5'b10000;
        rq(2, 1, 0, 5'b10000); rq(1, 1, 0, 5'b10000);
        #1;
        chk("sw_n_grant_s", grant_o, gv(4, 5'b00010));
        chk("sw_n_send_s", {20'd0, send_o}, 25'b00010);
        chk("sw_n_oval", {20'd0, out_valid_o}, 25'b10000);
        tick();
        chk("sw_n_locked", {20'd0, locked_o}, 25'b10000);
        rq(1, 0, 0, 5'b10000);
        #1;
        chk("s_body_grant", grant_o, gv(4, 5'b00010));
        chk("s_body_send", {20'd0, send_o}, 25'b00010);
        tick();
        rq(1, 0, 1, 5'b10000);
        #1;
        chk("s_tail_send", {20'd0, send_o}, 25'b00010);
        tick();
        chk("s_tail_unlock", {20'd0, locked_o}, '0);
        clr(); rq(2, 1, 0, 5'b10000);
        #1;
        chk("w_n_grant", grant_o, gv(4, 5'b00100));
        chk("w_n_send", {20'd0, send_o}, 25'b00100);
        tick();
        chk("w_n_locked", {20'd0, locked_o}, 25'b10000);
        rq(2, 0, 1, 5'b10000);
        #1;
        chk("w_n_tail", grant_o, gv(4, 5'b00100));
        tick();
        // ptr[4] = 3: E beats L and S
        clr(); rq(0, 1, 1, 5'b10000); rq(1, 1, 1, 5'b10000); rq(3, 1, 1, 5'b10000);
        #1;
        chk("ptr3_e_wins", grant_o, gv(4, 5'b01000));
        tick();
        chk("ptr3_no_lock", {20'd0, locked_o}, '0);
        // ptr[4] = 4: L beats S
        clr(); rq(0, 1, 1, 5'b10000); rq(1, 1, 1, 5'b10000);
        #1;
        chk("ptr4_l_wins", grant_o, gv(4, 5'b00001));
        tick();

        // W 3-flit packet to E, L head waiting from flit 2
        clr(); credit_avail_i = 5'b01000;
        rq(2, 1, 0, 5'b01000);
        #1;
        chk("we_head", grant_o, gv(3, 5'b00100));
        tick();
        chk("we_locked", {20'd0, locked_o}, 25'b01000);
        rq(2, 0, 0, 5'b01000); rq(0, 1, 0, 5'b01000);
        #1;
        chk("we_body_block_l", {20'd0, send_o}, 25'b00100);
        tick();
        rq(2, 0, 1, 5'b01000);
        #1;
        chk("we_tail_block_l", {20'd0, send_o}, 25'b00100);
        tick();
        chk("we_unlock", {20'd0, locked_o}, '0);
        chk("we_no_err", {24'd0, err_o}, '0);
        clr(); rq(0, 1, 0, 5'b01000);
        #1;
        chk("le_after_tail", grant_o, gv(3, 5'b00001));
        tick();
        rq(0, 0, 1, 5'b01000);
        #1;
        chk("le_tail", {20'd0, send_o}, 25'b00001);
        tick();

        // credit stall during W->E packet
        clr(); rq(2, 1, 0, 5'b01000);
        #1;
        chk("stall_head", {20'd0, send_o}, 25'b00100);
        tick();
        rq(2, 0, 0, 5'b01000); credit_avail_i = 5'b00000;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_oval", {20'd0, out_valid_o}, '0);
            chk("stall_send", {20'd0, send_o}, '0);
            tick();
            chk("stall_locked", {20'd0, locked_o}, 25'b01000);
            chk("stall_err", {24'd0, err_o}, '0);
        end
        credit_avail_i = 5'b01000;
        #1;
        chk("resume_oval", {20'd0, out_valid_o}, 25'b01000);
        chk("resume_send", {20'd0, send_o}, 25'b00100);
        tick();
        rq(2, 0, 1, 5'b01000);
        #1;
        chk("resume_tail", grant_o, gv(3, 5'b00100));
        tick();
        chk("resume_unlock", {20'd0, locked_o}, '0);

        // S U-turn
        clr(); credit_avail_i = 5'b11111;
        rq(1, 1, 1, 5'b00010);
        #1;
        chk("uturn_grant", grant_o, '0);
        chk("uturn_send", {20'd0, send_o}, '0);
        tick();
        chk("uturn_err", {24'd0, err_o}, 25'd1);
        clr();
        tick();
        chk("uturn_err_clear", {24'd0, err_o}, '0);

        // owner presents a second head while locked (ptr[4] = 1)
        rq(1, 1, 0, 5'b10000);
        #1;
        chk("own_head1", grant_o, gv(4, 5'b00010));
        tick();
        chk("own_locked", {20'd0, locked_o}, 25'b10000);
        chk("own_no_err", {24'd0, err_o}, '0);
        #1;
        chk("own_head2_grant", grant_o, '0);
        tick();
        chk("own_head2_err", {24'd0, err_o}, 25'd1);
        chk("own_lock_kept", {20'd0, locked_o}, 25'b10000);
        clr();
        tick();
        chk("own_err_clear", {24'd0, err_o}, '0);

        // reset in the middle of S's packet
        rq(1, 0, 0, 5'b10000); rst = 1'b1;
        #1;
        chk("midrst_grant", grant_o, '0);
        tick();
        chk("midrst_unlock", {20'd0, locked_o}, '0);
        rst = 1'b0; clr();

        // body flit to an idle output
        rq(3, 0, 0, 5'b00010);
        #1;
        chk("body_idle_grant", grant_o, '0);
        tick();
        chk("body_idle_err", {24'd0, err_o}, 25'd1);

        // all five outputs forward at once
        clr();
        rq(0, 1, 1, 5'b10000); rq(1, 1, 1, 5'b01000); rq(2, 1, 1, 5'b00001);
        rq(3, 1, 1, 5'b00100); rq(4, 1, 1, 5'b00010);
        #1;
        chk("all5_grant", grant_o,
            gv(4, 5'b00001) | gv(3, 5'b00010) | gv(0, 5'b00100) | gv(2, 5'b01000) | gv(1, 5'b10000));
        chk("all5_send", {20'd0, send_o}, 25'b11111);
        chk("all5_oval", {20'd0, out_valid_o}, 25'b11111);
        tick();
        chk("all5_err", {24'd0, err_o}, '0);
        chk("all5_locked", {20'd0, locked_o}, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Switch allocator for the 5-port wormhole router. Each cycle it matches buffered input flits to output ports.
- Per output port:
  - round-robin arbitration among competing packet heads;
  - the winning input holds the output until its tail flit passes (wormhole lock);
  - a flit is forwarded only when downstream credit is available.
- Drives the crossbar select, the input-buffer dequeue strobes and the credit-counter decrements.

Parameters:
NUM_PORTS, 5, number of router ports; only 5 is supported. Port index: 4=N, 3=E, 2=W, 1=S, 0=L.
RR_RESET, 0, reset value of every output's round-robin pointer (input index 0..4).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid_i  in  5  input i has a flit at its buffer head
req_head_i  in  5  flit at input i is a header
req_tail_i  in  5  flit at input i is a tail; head+tail means a single-flit packet
req_dir_i  in  25  one-hot target output for input i at [5i+4:5i]; bit o selects output o
credit_avail_i  in  5  output o's downstream credit count is nonzero
grant_o  out  25  crossbar select; output o at [5o+4:5o], bit i set = input i drives output o
send_o  out  5  dequeue strobe for input i this cycle
out_valid_o  out  5  output o forwards a flit this cycle; also the credit decrement pulse
locked_o  out  5  output o is currently owned by an in-flight packet
err_o  out  1  registered protocol-error pulse

Behaviour:
- State per output o:
  - lock (IDLE or LOCKED);
  - owner[o], 3 bits;
  - ptr[o], 3 bits, values 0..4.
- Plus the err_o register.
- Reset: while rst=1 at a clk edge, all outputs go IDLE, owner=0, ptr=RR_RESET and err_o=0. In the same cycle grant_o, send_o and out_valid_o are forced to 0.
- grant_o, send_o and out_valid_o are combinational from current state and inputs (zero-cycle grant). lock, owner, ptr and err_o update on the clk edge.
- Request legality: input i's request is legal when req_valid_i[i]=1, its dir field is exactly one-hot, and bit i is not set (no U-turn). Illegal requests are ignored, and err_o=1 on the next cycle for one cycle.
- IDLE output o:
  - Candidates: legal requests with head=1 and dir=o.
  - Search order: ptr[o], ptr[o]+1, ... mod 5; the first candidate wins.
  - Grant only if credit_avail_i[o]=1. Otherwise no grant, and ptr and lock are unchanged.
  - On a grant: ptr[o] <= (winner+1) mod 5.
  - If the winning flit also has tail=1, the output stays IDLE. Otherwise the output goes LOCKED with owner=winner.
  - Non-head flits aimed at an IDLE output are ignored and flagged in err_o.
- LOCKED output o:
  - Only owner's legal non-head request with dir=o is considered; it is granted if credit_avail_i[o]=1.
  - A tail grant returns the output to IDLE on the next edge. A new head to this output can win in the cycle after the tail.
  - All other requesters to o are blocked (no send_o). Blocking is not an error.
  - If the owner presents head=1, or its dir changes away from o, there is no grant and err_o pulses.
  - Credit loss mid-packet: grants stall while the lock is held.
- Grant outputs:
  - grant_o[5o+i] = out_valid_o[o] = 1 when input i is granted to output o.
  - send_o[i] = OR of input i's grants. At most one grant per input and per output.
- Different outputs are arbitrated independently and in parallel; all five outputs may forward in the same cycle.
- Reset asserted mid-packet drops all locks immediately. There is no flit flush; flushing is the buffers' job.

Test Plan:
- rst held 2 cycles with random requests -> grant_o=0, send_o=0, locked_o=0 during rst. After release, ptr=0 (verified by scenario 3 ordering) and err_o=0.
- L single-flit (head=1, tail=1, dir=5'b01000, credit_avail=5'b01000) -> same cycle grant_o[19:15]=5'b00001, send_o=5'b00001, out_valid_o=5'b01000. locked_o stays 0.
- W and S heads (multi-flit) to N in the same cycle, ptr[4]=0 -> S wins (grant_o[24:20]=5'b00010) and locked_o[4]=1. W is granted the cycle after S's tail, and ptr[4] becomes 3 after W's head.
- W 3-flit packet to E, with L head to E arriving at flit 2 -> L has send_o[0]=0 through W's tail cycle. L is granted in the next cycle.
- During a W->E packet, credit_avail_i[3]=0 for 3 cycles -> out_valid_o[3]=0 and locked_o[3]=1 held. Forwarding resumes with the next flit the cycle credit returns.
- S requests dir=5'b00010 (U-turn) -> no grant, err_o=1 next cycle only. Owner presents head while locked -> no grant, err_o pulse, lock kept.
